// File: rtl/qenc_pkg.sv
// Shared constants, step encoding and Gray-phase decoder for the quadrature encoder.
package qenc_pkg;

  localparam logic [1:0] QENC_REG_COUNT  = 2'd0;
  localparam logic [1:0] QENC_REG_CTRL   = 2'd1;
  localparam logic [1:0] QENC_REG_STATUS = 2'd2;
  localparam logic [1:0] QENC_REG_VEL    = 2'd3;

  localparam int QENC_CTRL_EN  = 0;
  localparam int QENC_CTRL_INV = 1;

  localparam int QENC_STAT_OVF = 0;
  localparam int QENC_STAT_UNF = 1;
  localparam int QENC_STAT_ERR = 2;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2,
    ERR  = 2'd3
  } qenc_step_e;

  // Position of an AB pair along the forward sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] qenc_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic qenc_step_e qenc_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    diff = qenc_phase(cur_ab) - qenc_phase(prev_ab);
    case (diff)
      2'd0:    return HOLD;
      2'd1:    return INC;
      2'd3:    return DEC;
      default: return ERR;
    endcase
  endfunction

endpackage

// File: rtl/qenc_channel.sv
// One encoder channel: 2-FF synchroniser, step decoder, counter, sticky flags and,
// when QENC_VELOCITY_EN is defined, a saturating velocity accumulator.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_a,
  input  logic               i_b,
  input  logic               i_en,
  input  logic               i_inv,
  input  logic               i_cnt_we,
  input  logic [COUNT_W-1:0] i_cnt_wdata,
  input  logic [COUNT_W-1:0] i_cnt_wmask,
  input  logic [2:0]         i_stat_clr,
  input  logic               i_win_last,
  output logic [COUNT_W-1:0] o_count,
  output logic [2:0]         o_status,
  output logic [31:0]        o_vel
);

  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [2:0]         status_q, status_d;
  logic               ovf_evt, unf_evt, err_evt;
  qenc_step_e         raw_step, step;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      sync1_q  <= {i_a, i_b};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  // A disabled channel yields HOLD so neither the count nor ERR can move.
  always_comb begin
    raw_step = qenc_decode(prev_q, sync2_q);
    step     = HOLD;
    if (i_en) begin
      step = raw_step;
      if (i_inv && raw_step == INC) step = DEC;
      else if (i_inv && raw_step == DEC) step = INC;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    err_evt = (step == ERR);
    if (i_cnt_we) begin
      count_d = (count_q & ~i_cnt_wmask) | (i_cnt_wdata & i_cnt_wmask);
    end else if (step == INC) begin
      count_d = count_q + 1'b1;
      ovf_evt = &count_q;
    end else if (step == DEC) begin
      count_d = count_q - 1'b1;
      unf_evt = ~|count_q;
    end
    status_d = (status_q & ~i_stat_clr) | {err_evt, unf_evt, ovf_evt};
  end

  assign o_count  = count_q;
  assign o_status = status_q;

`ifdef QENC_VELOCITY_EN
  localparam logic signed [31:0] VEL_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] VEL_MIN = -32'sh7FFF_FFFF;

  logic signed [31:0] acc_q, acc_d, acc_sum, vel_q, vel_d;

  // The closing cycle's step is folded into the sample before the accumulator clears.
  always_comb begin
    acc_sum = acc_q;
    if (step == INC && acc_q != VEL_MAX) acc_sum = acc_q + 32'sd1;
    else if (step == DEC && acc_q != VEL_MIN) acc_sum = acc_q - 32'sd1;
    acc_d = i_win_last ? '0 : acc_sum;
    vel_d = i_win_last ? acc_sum : vel_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_q <= '0;
      vel_q <= '0;
    end else begin
      acc_q <= acc_d;
      vel_q <= vel_d;
    end
  end

  assign o_vel = vel_q;
`else
  logic unused_win;
  assign unused_win = i_win_last;
  assign o_vel      = '0;
`endif

endmodule

// File: rtl/wb_quad_encoder_mc.sv
// Multi-channel Wishbone quadrature-encoder peripheral: bus FSM, register decode and read mux.
// Velocity measurement is built only when QENC_VELOCITY_EN is defined.
module wb_quad_encoder_mc
  import qenc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int COUNT_W    = 32,
  parameter int VEL_PERIOD = 1000000
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [29:0]                 i_wb_addr,
  input  logic [31:0]                 i_wb_data,
  input  logic [3:0]                  i_wb_sel,
  output logic                        o_wb_ack,
  output logic                        o_wb_stall,
  output logic [31:0]                 o_wb_data,
  input  logic [NUM_CH-1:0]           i_quad_a,
  input  logic [NUM_CH-1:0]           i_quad_b,
  output logic [NUM_CH*COUNT_W-1:0]   o_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [31:0]        rdata_q, rdata_d, rd_sel;
  logic               accept, wr_acc;
  logic [CH_W-1:0]    ch_idx;
  logic [1:0]         reg_sel;
  logic [31:0]        sel_mask;
  logic [NUM_CH-1:0]  en_q, inv_q;
  logic [NUM_CH-1:0]  cnt_we, ctrl_we;
  logic               win_last;
  logic [2:0]         stat_clr [NUM_CH];
  logic [COUNT_W-1:0] count_w  [NUM_CH];
  logic [2:0]         status_w [NUM_CH];
  logic [31:0]        vel_w    [NUM_CH];
  logic               unused_bits;

  assign ch_idx   = (NUM_CH > 1) ? i_wb_addr[2 +: CH_W] : '0;
  assign reg_sel  = i_wb_addr[1:0];
  assign accept   = (state_q == ST_IDLE) && i_wb_cyc && i_wb_stb;
  assign wr_acc   = accept && i_wb_we;
  assign sel_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign unused_bits = ^{i_wb_addr, i_wb_data, i_wb_sel};

`ifdef QENC_VELOCITY_EN
  localparam int WIN_W = (VEL_PERIOD > 2) ? $clog2(VEL_PERIOD) : 1;
  logic [WIN_W-1:0] win_q;

  assign win_last = (win_q == WIN_W'(VEL_PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)    win_q <= '0;
    else if (win_last) win_q <= '0;
    else               win_q <= win_q + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (VEL_PERIOD < 2);
  assign win_last   = 1'b0;
`endif

  // Channel indices at or above NUM_CH match no generate slot, so they read 0 and ignore writes.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic hit;
    assign hit        = wr_acc && (ch_idx == CH_W'(n));
    assign cnt_we[n]  = hit && (reg_sel == QENC_REG_COUNT);
    assign ctrl_we[n] = hit && (reg_sel == QENC_REG_CTRL);
    assign stat_clr[n] = (hit && reg_sel == QENC_REG_STATUS) ? i_wb_data[2:0] : 3'b000;

    qenc_channel #(
      .COUNT_W(COUNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_a        (i_quad_a[n]),
      .i_b        (i_quad_b[n]),
      .i_en       (en_q[n]),
      .i_inv      (inv_q[n]),
      .i_cnt_we   (cnt_we[n]),
      .i_cnt_wdata(i_wb_data[COUNT_W-1:0]),
      .i_cnt_wmask(sel_mask[COUNT_W-1:0]),
      .i_stat_clr (stat_clr[n]),
      .i_win_last (win_last),
      .o_count    (count_w[n]),
      .o_status   (status_w[n]),
      .o_vel      (vel_w[n])
    );

    assign o_count[n*COUNT_W +: COUNT_W] = count_w[n];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      en_q  <= '1;
      inv_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ctrl_we[n]) begin
          en_q[n]  <= i_wb_data[QENC_CTRL_EN];
          inv_q[n] <= i_wb_data[QENC_CTRL_INV];
        end
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_idx == CH_W'(n)) begin
        case (reg_sel)
          QENC_REG_COUNT:  rd_sel[COUNT_W-1:0] = count_w[n];
          QENC_REG_CTRL:   rd_sel = {30'd0, inv_q[n], en_q[n]};
          QENC_REG_STATUS: rd_sel = {29'd0, status_w[n]};
          default:         rd_sel = vel_w[n];
        endcase
      end
    end
  end

  // Read data is captured from pre-write register values on the accept edge.
  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACK;
          rdata_d = i_wb_we ? 32'd0 : rd_sel;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_wb_ack   = (state_q == ST_ACK);
  assign o_wb_stall = (state_q != ST_IDLE);
  assign o_wb_data  = rdata_q;

endmodule

// File: tb/tb_wb_quad_encoder_mc.sv
// Scoreboard bench for wb_quad_encoder_mc: bus requests push expectations, a monitor checks acks.
module tb_wb_quad_encoder_mc;
  import qenc_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int COUNT_W    = 32;
  localparam int VEL_PERIOD = 100;

  typedef struct {
    logic        isRead;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rstN;
  logic                      cyc, stb, we;
  logic [29:0]               addr;
  logic [31:0]               wdata;
  logic [3:0]                sel;
  logic                      ackO, stallO;
  logic [31:0]               dataO;
  logic [NUM_CH-1:0]         qa, qb;
  logic [NUM_CH*COUNT_W-1:0] countO;

  exp_t sbQ[$];
  int   assertions = 0;
  int   failures   = 0;
  int   cycK       = 0;
  int   phase[NUM_CH];

  wb_quad_encoder_mc #(
    .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .VEL_PERIOD(VEL_PERIOD)
  ) dut (
    .i_clk(clk), .i_reset_n(rstN),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(ackO), .o_wb_stall(stallO), .o_wb_data(dataO),
    .i_quad_a(qa), .i_quad_b(qb), .o_count(countO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rstN) cycK <= cycK + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic boundExpired(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [29:0] addrOf(input int ch, input logic [1:0] r);
    return 30'(ch << 2) | {28'd0, r};
  endfunction

  function automatic logic [1:0] abOf(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // One request, started on a negedge; returns on a negedge with the bus idle again.
  task automatic busXfer(input logic isWr, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (stallO && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) boundExpired({name, " stall"});
    e.isRead = !isWr;
    e.exp    = exp;
    e.name   = name;
    sbQ.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = isWr; addr = a; wdata = d; sel = s;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic busRead(input int ch, input logic [1:0] r, input logic [31:0] exp, input string name);
    busXfer(1'b0, addrOf(ch, r), 32'd0, 4'h0, exp, name);
  endtask

  task automatic busWrite(input int ch, input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    busXfer(1'b1, addrOf(ch, r), d, s, 32'd0, "write");
  endtask

  // Each edge is held for 4 cycles so the count has settled before the next edge.
  task automatic applyStimulus(input int ch, input int edges, input int dir);
    logic [1:0] ab;
    for (int i = 0; i < edges; i++) begin
      @(negedge clk);
      phase[ch] = (phase[ch] + dir) & 3;
      ab = abOf(phase[ch]);
      qa[ch] = ab[1];
      qb[ch] = ab[0];
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic waitPhase(input int p);
    int guard;
    guard = 0;
    while ((cycK % VEL_PERIOD) != p && guard < 3 * VEL_PERIOD) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3 * VEL_PERIOD) boundExpired("window phase");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ackO) begin
        if (sbQ.size() == 0) begin
          boundExpired("unexpected ack");
        end else begin
          e = sbQ.pop_front();
          if (e.isRead) checkOutput(e.name, dataO, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [1:0] ab;
    rstN = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; qa = '0; qb = '0;
    for (int i = 0; i < NUM_CH; i++) phase[i] = 0;
    repeat (4) @(negedge clk);
    rstN = 1'b1;

    checkOutput("reset o_count lo", countO[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    checkOutput("reset o_count hi", countO[127:64] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    busRead(0, QENC_REG_COUNT,  32'd0, "reset COUNT0");
    busRead(0, QENC_REG_CTRL,   32'd1, "reset CTRL0");
    busRead(3, QENC_REG_CTRL,   32'd1, "reset CTRL3");
    busRead(0, QENC_REG_STATUS, 32'd0, "reset STATUS0");
    busRead(0, QENC_REG_VEL,    32'd0, "reset VEL0");

    applyStimulus(0, 16, 1);
    busRead(0, QENC_REG_COUNT, 32'd16, "ch0 fwd COUNT0");
    busRead(1, QENC_REG_COUNT, 32'd0,  "ch0 fwd COUNT1");
    busRead(2, QENC_REG_COUNT, 32'd0,  "ch0 fwd COUNT2");
    busRead(3, QENC_REG_COUNT, 32'd0,  "ch0 fwd COUNT3");
    checkOutput("ch0 o_count", countO[31:0], 32'd16);
    busXfer(1'b0, 30'h10 | addrOf(0, QENC_REG_COUNT), 32'd0, 4'h0, 32'd16, "high addr bits ignored");

    busWrite(1, QENC_REG_CTRL, 32'd3, 4'hF);
    busRead(1, QENC_REG_CTRL, 32'd3, "CTRL1 readback");
    applyStimulus(1, 3, 1);
    busRead(1, QENC_REG_COUNT,  32'hFFFF_FFFD, "inv COUNT1");
    busRead(1, QENC_REG_STATUS, 32'd2,         "inv UNF set");
    busWrite(1, QENC_REG_STATUS, 32'd2, 4'hF);
    busRead(1, QENC_REG_STATUS, 32'd0,         "UNF cleared");
    busRead(1, QENC_REG_COUNT,  32'hFFFF_FFFD, "COUNT1 after clear");

    busWrite(2, QENC_REG_COUNT, 32'hFFFF_FFFF, 4'b1111);
    busRead(2, QENC_REG_COUNT, 32'hFFFF_FFFF, "COUNT2 loaded");
    applyStimulus(2, 1, 1);
    busRead(2, QENC_REG_COUNT,  32'd0, "COUNT2 wrapped");
    busRead(2, QENC_REG_STATUS, 32'd1, "OVF set");
    busWrite(2, QENC_REG_COUNT, 32'hAABB_CC55, 4'b0001);
    busRead(2, QENC_REG_COUNT, 32'h0000_0055, "sel 0001 write");
    busWrite(2, QENC_REG_COUNT, 32'h0012_0000, 4'b0100);
    busRead(2, QENC_REG_COUNT, 32'h0012_0055, "sel 0100 write");

    @(negedge clk);
    qa[3] = 1'b1; qb[3] = 1'b1; phase[3] = 2;
    repeat (4) @(negedge clk);
    busRead(3, QENC_REG_STATUS, 32'd4, "ERR set");
    busRead(3, QENC_REG_COUNT,  32'd0, "ERR count held");
    busWrite(3, QENC_REG_STATUS, 32'd4, 4'hF);
    busRead(3, QENC_REG_STATUS, 32'd0, "ERR cleared");
    busWrite(3, QENC_REG_CTRL, 32'd0, 4'hF);
    @(negedge clk);
    qa[3] = 1'b0; qb[3] = 1'b0; phase[3] = 0;
    repeat (4) @(negedge clk);
    busRead(3, QENC_REG_STATUS, 32'd0, "EN=0 no ERR");
    applyStimulus(3, 2, 1);
    busRead(3, QENC_REG_COUNT, 32'd0, "EN=0 no count");
    busWrite(3, QENC_REG_CTRL, 32'd1, 4'hF);
    applyStimulus(3, 1, 1);
    busRead(3, QENC_REG_COUNT,  32'd1, "re-enabled count");
    busRead(3, QENC_REG_STATUS, 32'd0, "re-enabled no ERR");

    // The edge reaches the counter on the third posedge, the same edge that accepts the write.
    @(negedge clk);
    phase[0] = (phase[0] + 1) & 3;
    ab = abOf(phase[0]);
    qa[0] = ab[1]; qb[0] = ab[0];
    @(negedge clk);
    busWrite(0, QENC_REG_COUNT, 32'h0000_1234, 4'hF);
    repeat (4) @(negedge clk);
    checkOutput("write beats step o_count", countO[31:0], 32'h0000_1234);
    busRead(0, QENC_REG_COUNT, 32'h0000_1234, "write beats step COUNT0");

    begin : backToBack
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        e.isRead = 1'b1;
        e.exp    = 32'h0000_1234;
        e.name   = "b2b read";
        sbQ.push_back(e);
      end
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = addrOf(0, QENC_REG_COUNT);
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        checkOutput("b2b ack", {31'd0, ackO},   (i % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput("b2b stall", {31'd0, stallO}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      repeat (2) @(negedge clk);
    end

`ifdef QENC_VELOCITY_EN
    waitPhase(2);
    applyStimulus(1, 10, -1);
    applyStimulus(0, 10, 1);
    waitPhase(30);
    busRead(0, QENC_REG_VEL, 32'd20 - 32'd10 + 32'd0, "VEL0 after window");
    busRead(1, QENC_REG_VEL, 32'd10, "VEL1 inverted after window");
    @(negedge clk);
    waitPhase(30);
    busRead(0, QENC_REG_VEL, 32'd0, "VEL0 idle window");
`else
    applyStimulus(0, 10, 1);
    busRead(0, QENC_REG_VEL, 32'd0, "VEL0 disabled");
`endif

    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
